// File: rtl/spi_master_core_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_core_if
// Purpose  : Sequencer handshake and SPI pad bundle for spi_master_core.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_master_core_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 1,
    parameter int CSW    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
);
    logic              start_sig;
    logic [DATA_W-1:0] tx_data;
    logic              keep_cs;
    logic [CSW-1:0]    cs_sel;
    logic              release_sig;
    logic              spi_in;
    logic              busy;
    logic              done_sig;
    logic [DATA_W-1:0] spi_rdata;
    logic              spi_clk;
    logic              spi_mosi;
    logic [NUM_CS-1:0] spi_cs_n;

    // master: command sequencer plus MISO pad; slave: the SPI engine
    modport master (
        output start_sig, tx_data, keep_cs, cs_sel, release_sig, spi_in,
        input  busy, done_sig, spi_rdata, spi_clk, spi_mosi, spi_cs_n
    );

    modport slave (
        input  start_sig, tx_data, keep_cs, cs_sel, release_sig, spi_in,
        output busy, done_sig, spi_rdata, spi_clk, spi_mosi, spi_cs_n
    );
endinterface
`default_nettype wire

// File: rtl/spi_master_core.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_core
// Purpose  : Parametrised SPI master engine: word width, divider, CPOL/CPHA,
//            multiple chip selects, full-duplex receive, CS hold across words.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_core #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter bit CPOL    = 1'b0,
    parameter bit CPHA    = 1'b0,
    parameter int NUM_CS  = 1
) (
    input wire               clk,
    input wire               rst,
    spi_master_core_if.slave bus
);
    localparam int CSW   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HLF_W = $clog2(2 * DATA_W);

    localparam logic [CNT_W-1:0] c_cnt_load  = CNT_W'(CLK_DIV - 1);
    localparam logic [HLF_W-1:0] c_half_last = HLF_W'(2 * DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GAP   = 3'd1,
        ST_SETUP = 3'd2,
        ST_SHIFT = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [HLF_W-1:0]  r_half;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic              r_keep;
    logic [CSW-1:0]    r_sel;
    logic              r_held;
    logic              r_spi_clk;
    logic              r_mosi;
    logic [NUM_CS-1:0] r_cs_n;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_rdata;

    // Out-of-range indices leave every chip select deasserted.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CSW-1:0] sel);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (sel == CSW'(i)) v[i] = 1'b0;
        end
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_half    <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_keep    <= 1'b0;
            r_sel     <= '0;
            r_held    <= 1'b0;
            r_spi_clk <= CPOL;
            r_mosi    <= 1'b0;
            r_cs_n    <= '1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_sig) begin
                        r_tx   <= bus.tx_data;
                        r_keep <= bus.keep_cs;
                        r_sel  <= bus.cs_sel;
                        r_busy <= 1'b1;
                        r_cnt  <= c_cnt_load;
                        r_half <= '0;
                        // MSB presented early so CPHA=0 has it before the first leading edge
                        r_mosi <= bus.tx_data[DATA_W-1];
                        if (r_held && (bus.cs_sel == r_sel)) begin
                            r_state <= ST_SHIFT;
                        end else if (r_held) begin
                            r_state <= ST_GAP;
                            r_cs_n  <= '1;
                            r_held  <= 1'b0;
                        end else begin
                            r_state <= ST_SETUP;
                            r_cs_n  <= cs_decode(bus.cs_sel);
                        end
                    end else if (bus.release_sig) begin
                        r_cs_n <= '1;
                        r_held <= 1'b0;
                    end
                end

                ST_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_SETUP;
                        r_cnt   <= c_cnt_load;
                        r_cs_n  <= cs_decode(r_sel);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                ST_SETUP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_SHIFT;
                        r_cnt   <= c_cnt_load;
                        r_half  <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (r_cnt == '0) begin
                        r_cnt     <= c_cnt_load;
                        r_spi_clk <= ~r_spi_clk;
                        r_half    <= r_half + 1'b1;
                        // even half index ends on a leading edge, odd on a trailing edge
                        if (r_half[0] == 1'b0) begin
                            if (CPHA) begin
                                r_mosi <= r_tx[DATA_W-1];
                                r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                            end else begin
                                r_rx <= {r_rx[DATA_W-2:0], bus.spi_in};
                            end
                        end else begin
                            if (CPHA) begin
                                r_rx <= {r_rx[DATA_W-2:0], bus.spi_in};
                            end else if (r_half != c_half_last) begin
                                r_mosi <= r_tx[DATA_W-2];
                                r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                            end
                        end
                        if (r_half == c_half_last) r_state <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_rdata <= r_rx;
                        if (r_keep) begin
                            r_held <= 1'b1;
                        end else begin
                            r_cs_n <= '1;
                            r_held <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done_sig  = r_done;
    assign bus.spi_rdata = r_rdata;
    assign bus.spi_clk   = r_spi_clk;
    assign bus.spi_mosi  = r_mosi;
    assign bus.spi_cs_n  = r_cs_n;
endmodule
`default_nettype wire

// File: tb/tb_spi_master_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_core
// Purpose  : Directed self-checking bench for spi_master_core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_core;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    spi_master_core_if #(.DATA_W(8), .NUM_CS(4)) bus_a ();
    spi_master_core_if #(.DATA_W(8), .NUM_CS(1)) bus_b ();

    spi_master_core #(.DATA_W(8), .CLK_DIV(4), .CPOL(1'b0), .CPHA(1'b0), .NUM_CS(4)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    spi_master_core #(.DATA_W(8), .CLK_DIV(4), .CPOL(1'b1), .CPHA(1'b1), .NUM_CS(1)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // dut_a: MISO looped back to MOSI
    assign bus_a.spi_in = bus_a.spi_mosi;

    // dut_b: mode-3 slave shifting out a fixed word on leading (falling) edges
    localparam logic [7:0] c_slave_word = 8'h3C;
    logic [2:0] r_slv_idx = 3'd0;
    logic       r_miso    = 1'b0;
    always @(negedge bus_b.spi_clk or posedge bus_b.spi_cs_n[0]) begin
        if (bus_b.spi_cs_n[0]) begin
            r_slv_idx <= 3'd0;
        end else begin
            r_miso    <= c_slave_word[3'd7 - r_slv_idx];
            r_slv_idx <= r_slv_idx + 3'd1;
        end
    end
    assign bus_b.spi_in = r_miso;

    int         n_a_lead = 0, n_b_fall = 0, n_b_rise = 0;
    int         n_a_done = 0, n_a_cs0_hi = 0, n_b_cs_lo = 0;
    logic [7:0] r_mosi_cap = 8'h00;

    always @(posedge bus_a.spi_clk) begin
        n_a_lead   <= n_a_lead + 1;
        r_mosi_cap <= {r_mosi_cap[6:0], bus_a.spi_mosi};
    end
    always @(negedge bus_b.spi_clk) n_b_fall <= n_b_fall + 1;
    always @(posedge bus_b.spi_clk) n_b_rise <= n_b_rise + 1;
    always @(posedge clk) begin
        if (bus_a.done_sig)     n_a_done   <= n_a_done + 1;
        if (bus_a.spi_cs_n[0])  n_a_cs0_hi <= n_a_cs0_hi + 1;
        if (!bus_b.spi_cs_n[0]) n_b_cs_lo  <= n_b_cs_lo + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called #1 after a clk edge; returns cycles from the start-asserted cycle to Done_Sig.
    task automatic word_a(input logic [7:0] tx, input logic keep, input logic [1:0] sel,
                          output int lat);
        int guard;
        guard = 0;
        while (bus_a.busy && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        bus_a.tx_data   = tx;
        bus_a.keep_cs   = keep;
        bus_a.cs_sel    = sel;
        bus_a.start_sig = 1'b1;
        @(posedge clk); #1;
        bus_a.start_sig = 1'b0;
        lat = 1;
        while (!bus_a.done_sig && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic word_b(input logic [7:0] tx, input logic sel, output int lat);
        bus_b.tx_data   = tx;
        bus_b.keep_cs   = 1'b0;
        bus_b.cs_sel    = sel;
        bus_b.start_sig = 1'b1;
        @(posedge clk); #1;
        bus_b.start_sig = 1'b0;
        lat = 1;
        while (!bus_b.done_sig && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int s0;
        int s1;
        int gap_hi;

        bus_a.start_sig = 1'b0; bus_a.tx_data = 8'h00; bus_a.keep_cs = 1'b0;
        bus_a.cs_sel = 2'd0;    bus_a.release_sig = 1'b0;
        bus_b.start_sig = 1'b0; bus_b.tx_data = 8'h00; bus_b.keep_cs = 1'b0;
        bus_b.cs_sel = 1'b0;    bus_b.release_sig = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n",    bus_a.spi_cs_n,  4'hF);
        chk("rst_clk_a",   bus_a.spi_clk,   1'b0);
        chk("rst_clk_b",   bus_b.spi_clk,   1'b1);
        chk("rst_mosi",    bus_a.spi_mosi,  1'b0);
        chk("rst_busy",    bus_a.busy,      1'b0);
        chk("rst_done",    bus_a.done_sig,  1'b0);
        chk("rst_rdata",   bus_a.spi_rdata, 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;

        // basic word with loopback
        s0 = n_a_lead;
        word_a(8'hA5, 1'b0, 2'd0, lat);
        chk("t1_latency",    lat,                73);
        chk("t1_rdata",      bus_a.spi_rdata,    8'hA5);
        chk("t1_mosi_bits",  r_mosi_cap,         8'hA5);
        chk("t1_lead_edges", n_a_lead - s0,      8);
        chk("t1_cs_release", bus_a.spi_cs_n,     4'hF);
        chk("t1_clk_idle",   bus_a.spi_clk,      1'b0);

        // mode 3 against slave model
        s0 = n_b_fall;
        s1 = n_b_rise;
        chk("t2_clk_idle_pre", bus_b.spi_clk, 1'b1);
        word_b(8'h5A, 1'b0, lat);
        chk("t2_latency",      lat,            73);
        chk("t2_rdata",        bus_b.spi_rdata, 8'h3C);
        chk("t2_sample_edges", n_b_rise - s1,  8);
        chk("t2_lead_edges",   n_b_fall - s0,  8);
        chk("t2_clk_idle_end", bus_b.spi_clk,  1'b1);

        // out-of-range select: no CS, still completes
        @(posedge clk); #1;
        @(posedge clk); #1;
        s0 = n_b_cs_lo;
        word_b(8'hF0, 1'b1, lat);
        chk("oor_latency", lat,             73);
        chk("oor_no_cs",   n_b_cs_lo - s0,  0);

        // CS held across two words
        word_a(8'h0B, 1'b1, 2'd0, lat);
        chk("t3_lat_first",   lat,             73);
        chk("t3_rdata_first", bus_a.spi_rdata, 8'h0B);
        chk("t3_cs_held",     bus_a.spi_cs_n,  4'b1110);
        s1 = n_a_cs0_hi;
        word_a(8'h00, 1'b0, 2'd0, lat);
        chk("t3_lat_chained",   lat,               69);
        chk("t3_cs_continuous", n_a_cs0_hi - s1,   0);
        chk("t3_rdata_second",  bus_a.spi_rdata,   8'h00);
        chk("t3_cs_release",    bus_a.spi_cs_n,    4'hF);

        // held CS1 then switch to CS2 through the gap
        word_a(8'h5A, 1'b1, 2'd1, lat);
        chk("t4_lat",      lat,            73);
        chk("t4_cs1_held", bus_a.spi_cs_n, 4'b1101);
        @(posedge clk); #1;
        bus_a.tx_data = 8'h81; bus_a.keep_cs = 1'b0; bus_a.cs_sel = 2'd2;
        bus_a.start_sig = 1'b1;
        @(posedge clk); #1;
        bus_a.start_sig = 1'b0;
        gap_hi = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus_a.spi_cs_n == 4'hF) gap_hi++;
            @(posedge clk); #1;
        end
        chk("t4_gap_cycles",   gap_hi,         4);
        chk("t4_cs2_selected", bus_a.spi_cs_n, 4'b1011);
        lat = 0;
        while (!bus_a.done_sig && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("t4_rdata",   bus_a.spi_rdata, 8'h81);
        chk("t4_cs_end",  bus_a.spi_cs_n,  4'hF);

        // release of a held CS, then a fresh word takes the SETUP path
        word_a(8'hC3, 1'b1, 2'd3, lat);
        chk("rel_cs3_held", bus_a.spi_cs_n, 4'b0111);
        @(posedge clk); #1;
        bus_a.release_sig = 1'b1;
        @(posedge clk); #1;
        bus_a.release_sig = 1'b0;
        chk("rel_cs_high", bus_a.spi_cs_n, 4'hF);
        word_a(8'h3C, 1'b0, 2'd3, lat);
        chk("rel_setup_lat", lat, 73);

        // reset mid-SHIFT
        @(posedge clk); #1;
        @(posedge clk); #1;
        s0 = n_a_done;
        bus_a.tx_data = 8'hFF; bus_a.keep_cs = 1'b0; bus_a.cs_sel = 2'd0;
        bus_a.start_sig = 1'b1;
        @(posedge clk); #1;
        bus_a.start_sig = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        chk("t5_pre_cs_low",   bus_a.spi_cs_n, 4'b1110);
        chk("t5_pre_clk_high", bus_a.spi_clk,  1'b1);
        rst = 1'b1;
        #1;
        chk("t5_rst_cs",   bus_a.spi_cs_n, 4'hF);
        chk("t5_rst_clk",  bus_a.spi_clk,  1'b0);
        chk("t5_rst_busy", bus_a.busy,     1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("t5_no_done", n_a_done - s0, 0);
        word_a(8'h96, 1'b0, 2'd0, lat);
        chk("t5_next_lat",   lat,             73);
        chk("t5_next_rdata", bus_a.spi_rdata, 8'h96);

        // Start while busy and during DONE is ignored
        @(posedge clk); #1;
        @(posedge clk); #1;
        s0 = n_a_done;
        bus_a.tx_data = 8'h6E; bus_a.keep_cs = 1'b0; bus_a.cs_sel = 2'd0;
        bus_a.start_sig = 1'b1;
        @(posedge clk); #1;
        bus_a.start_sig = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus_a.tx_data = 8'h11;
        bus_a.start_sig = 1'b1;
        @(posedge clk); #1;
        bus_a.start_sig = 1'b0;
        lat = 0;
        while (!bus_a.done_sig && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("t6_rdata", bus_a.spi_rdata, 8'h6E);
        bus_a.start_sig = 1'b1;
        @(posedge clk); #1;
        bus_a.start_sig = 1'b0;
        chk("t6_idle_after_done", bus_a.busy, 1'b0);
        repeat (150) @(posedge clk);
        #1;
        chk("t6_one_done", n_a_done - s0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
